// File: rtl/serial_adder.sv
// Bit-serial adder: latches a/b/cin, adds one bit per cycle LSB first, then holds the result until it is handshaked.
// Optional two's-complement overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             carry_q;
  logic             carry_d;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;

  logic bit_a;
  logic bit_b;
  logic ha1_s;
  logic ha1_c;
  logic ha2_s;
  logic ha2_c;

`ifdef SERIAL_ADDER_OVF_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
`endif

  // Two half-adder stages plus OR on the current LSB of the shifting operands.
  always_comb begin
    bit_a   = a_q[0];
    bit_b   = b_q[0];
    ha1_s   = bit_a ^ bit_b;
    ha1_c   = bit_a & bit_b;
    ha2_s   = ha1_s ^ carry_q;
    ha2_c   = ha1_s & carry_q;
    carry_d = ha1_c | ha2_c;
    sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
  end

  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  // Handshake outputs are forced low while reset is held, regardless of state.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign busy      = (state_q != IDLE) && !rst;
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          // Counter saturates at WIDTH-1; leaving RUN is what ends the operation.
          if (last_bit) begin
            cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= (a_msb_q == b_msb_q) && (ha2_s != a_msb_q);
`endif
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  operand set a/b/cin is valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-006 The block SHALL have ports a and b  input  WIDTH  unsigned operands.
REQ-007 The block SHALL have port cin  input  1  carry-in.
REQ-008 The block SHALL have port out_valid  output  1  result is valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 The block SHALL have port sum  output  WIDTH  result bits.
REQ-011 The block SHALL have port cout  output  1  carry-out of the MSB.
REQ-012 The block SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after WIDTH RUN cycles; DONE -> IDLE on out_valid&&out_ready.
REQ-014 in_ready SHALL be 1 only in IDLE and rst low; it SHALL be 0 in RUN and DONE.
REQ-015 On acceptance the block SHALL latch a, b and cin into internal registers; later changes on a/b/cin SHALL be ignored until the next acceptance.
REQ-016 In RUN the block SHALL add one bit per cycle, LSB first, using two half-adder stages plus OR: s = a[i]^b[i]^c, c_next = (a[i]&b[i]) | (c&(a[i]^b[i])).
REQ-017 In RUN the block SHALL shift s into the MSB of the sum register, shifting right, so that sum[i] holds bit i after WIDTH cycles.
REQ-018 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide, cleared on acceptance, and SHALL not wrap during RUN.
REQ-019 out_valid SHALL rise exactly WIDTH clock edges after the accepting edge; cout SHALL equal the final carry.
REQ-020 In DONE, sum, cout and out_valid SHALL hold stable while out_ready is low (unbounded backpressure).
REQ-021 After the DONE handshake, in_ready SHALL be 1 in the following cycle; there SHALL be no same-cycle bypass, so back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 sum and cout SHALL keep the last result in IDLE; they are defined only while out_valid is 1.
REQ-023 in_valid in RUN or DONE SHALL have no effect; the producer holds it until in_ready.

Reset
REQ-024 While rst is high at a clock edge, the block SHALL enter IDLE and clear sum, cout, carry and the counter to 0.
REQ-025 While rst is high, out_valid SHALL be 0, busy SHALL be 0 and in_ready SHALL be 0.
REQ-026 Reset in RUN or DONE SHALL abort the operation, discard the result and produce no out_valid pulse.

Configuration
REQ-027 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add port ovf  output  1  two's-complement overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), registered, valid with out_valid, reset to 0.
REQ-028 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8)
REQ-029 Bench SHALL apply a=00 b=00 cin=0 -> out_valid rises 8 edges after acceptance, sum=00, cout=0.
REQ-030 Bench SHALL apply a=FF b=01 cin=0 -> sum=00, cout=1; then a=A5 b=5A cin=1 -> sum=00, cout=1.
REQ-031 Bench SHALL apply a=7F b=01 cin=0 with SERIAL_ADDER_OVF_EN -> sum=80, cout=0, ovf=1; a=80 b=80 -> sum=00, cout=1, ovf=1.
REQ-032 Bench SHALL hold out_ready low for 5 cycles after out_valid -> sum/cout stable, in_ready=0, busy=1; release it -> in_ready=1 the next cycle.
REQ-033 Bench SHALL assert rst for 1 cycle at RUN bit 3 -> no out_valid, in_ready=1 after rst low, and the next operation (0x12+0x34) gives sum=46.
REQ-034 Bench SHALL run an exhaustive or 1000-vector random sweep with in_valid held and out_ready held -> every result equals a+b+cin, with cycle spacing WIDTH+2.
